// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin time-sharing of one serial sequence detector among N sources
//
// Ports:
//   clk, rst       clock (rising edge) and synchronous active-high reset
//   req[N]         per-source request level, held while service is wanted
//   ser_in[N]      per-source serial bit, only the granted source is used
//   grant[N]       registered one-hot grant, high during CLEAR and RUN
//   busy           high whenever the scheduler is not idle
//   det_rst        shared detector reset, one cycle in CLEAR
//   det_in         shared detector input, granted source's bit in RUN
//   det_hit        shared detector Mealy output, same cycle as det_in
//   done           one-cycle pulse in REPORT
//   done_id/done_hits/done_abort  result of the last window, held until next done
module seq_detect_sched #(
    parameter int N      = 4,
    parameter int WINDOW = 8,
    parameter int IDW    = $clog2(N),
    parameter int CW     = $clog2(WINDOW + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   ser_in,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic           det_rst,
    output logic           det_in,
    input  logic           det_hit,
    output logic           done,
    output logic [IDW-1:0] done_id,
    output logic [CW-1:0]  done_hits,
    output logic           done_abort
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gid;
    logic [CW-1:0]  bit_cnt;
    logic [CW-1:0]  hit_cnt;

    logic [IDW-1:0] pick_id;
    logic           pick_found;
    logic           src_req;
    logic           last_bit;
    logic [CW-1:0]  hit_cnt_inc;
    logic [IDW-1:0] gid_next;

    // First requester at or above rr_ptr, wrapping; found flag stops later matches.
    always_comb begin
        pick_id    = '0;
        pick_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(idx);
            end
        end
    end

    assign src_req     = req[gid];
    assign last_bit    = (bit_cnt == CW'(WINDOW - 1));
    assign hit_cnt_inc = hit_cnt + CW'(det_hit);
    assign gid_next    = (gid == IDW'(N - 1)) ? '0 : gid + 1'b1;

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        det_rst   = 1'b0;
        det_in    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:   if (pick_found) state_nxt = CLEAR;
            CLEAR: begin
                det_rst   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                // A dropped request takes priority: its bit is not streamed.
                if (!src_req) begin
                    state_nxt = REPORT;
                end else begin
                    det_in = ser_in[gid];
                    if (last_bit) state_nxt = REPORT;
                end
            end
            REPORT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gid        <= '0;
            bit_cnt    <= '0;
            hit_cnt    <= '0;
            grant      <= '0;
            done_id    <= '0;
            done_hits  <= '0;
            done_abort <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gid   <= pick_id;
                        grant <= N'(1) << pick_id;
                    end
                end
                CLEAR: begin
                    bit_cnt <= '0;
                    hit_cnt <= '0;
                end
                RUN: begin
                    if (!src_req) begin
                        grant      <= '0;
                        done_id    <= gid;
                        done_hits  <= hit_cnt;
                        done_abort <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        hit_cnt <= hit_cnt_inc;
                        if (last_bit) begin
                            // Include a hit on the final bit in the report.
                            grant      <= '0;
                            done_id    <= gid;
                            done_hits  <= hit_cnt_inc;
                            done_abort <= 1'b0;
                        end
                    end
                end
                REPORT: rr_ptr <= gid_next;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - directed self-checking bench for seq_detect_sched with a 1011 Mealy detector
module tb_seq_detect_sched;

    localparam int N      = 4;
    localparam int WINDOW = 8;
    localparam int IDW    = 2;
    localparam int CW     = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   ser_in;
    logic [N-1:0]   grant;
    logic           busy;
    logic           det_rst;
    logic           det_in;
    logic           det_hit;
    logic           done;
    logic [IDW-1:0] done_id;
    logic [CW-1:0]  done_hits;
    logic           done_abort;

    int total = 0;
    int bad   = 0;
    int done_pulses = 0;
    int wcnt;
    int cyc;

    always #5 clk = ~clk;

    seq_detect_sched #(.N(N), .WINDOW(WINDOW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ser_in     (ser_in),
        .grant      (grant),
        .busy       (busy),
        .det_rst    (det_rst),
        .det_in     (det_in),
        .det_hit    (det_hit),
        .done       (done),
        .done_id    (done_id),
        .done_hits  (done_hits),
        .done_abort (done_abort)
    );

    // Overlapping Mealy "1011" detector: 0=none, 1="1", 2="10", 3="101".
    logic [1:0] dstate;
    assign det_hit = (dstate == 2'd3) && det_in;
    always_ff @(posedge clk) begin
        if (det_rst) dstate <= 2'd0;
        else begin
            case (dstate)
                2'd0: dstate <= det_in ? 2'd1 : 2'd0;
                2'd1: dstate <= det_in ? 2'd1 : 2'd2;
                2'd2: dstate <= det_in ? 2'd3 : 2'd0;
                default: dstate <= det_in ? 2'd1 : 2'd2;
            endcase
        end
    end

    always @(negedge clk) if (done) done_pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for CLEAR, streams bits (bits[7] first) for src, stops at abort_at
    // by driving abort_req, then expects done. w = cycles to CLEAR, c = cycles to done.
    task automatic run_window(input int src, input logic [7:0] bits, input int abort_at,
                              input logic [N-1:0] abort_req, output int w, output int c);
        w = 0;
        while (!det_rst && w < 20) begin
            step();
            w++;
        end
        if (!det_rst) begin
            chk("clear_timeout", 32'(det_rst), 32'd1);
            c = w;
            return;
        end
        chk("clear_grant", 32'(grant), 32'(N'(1) << src));
        c = w;
        for (int i = 0; i < WINDOW; i++) begin
            step();
            c++;
            chk("run_grant", 32'(grant), 32'(N'(1) << src));
            if (i == abort_at) begin
                req = abort_req;
                break;
            end
            ser_in[src] = bits[7-i];
        end
        step();
        c++;
        chk("done", 32'(done), 32'd1);
        chk("report_grant", 32'(grant), 32'd0);
        ser_in = '0;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 4'b1111;
        ser_in = '0;
        step();
        step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_det_rst", 32'(det_rst), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        rst = 1'b0;

        // Round robin with all requests held.
        for (int k = 0; k < 5; k++) begin
            run_window(k % 4, 8'h00, -1, '0, wcnt, cyc);
            if (k == 4) req = '0;
            chk("rr_id", 32'(done_id), 32'(k % 4));
            chk("rr_hits", 32'(done_hits), 32'd0);
            chk("rr_abort", 32'(done_abort), 32'd0);
            chk("rr_gap", 32'(wcnt), (k == 0) ? 32'd1 : 32'd2);
        end
        step();
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("held_id", 32'(done_id), 32'd0);

        // Two hits in a full window, checked latency.
        req = 4'b0001;
        run_window(0, 8'b1011_0110, -1, '0, wcnt, cyc);
        chk("t2_latency", 32'(cyc), 32'd10);
        chk("t2_id", 32'(done_id), 32'd0);
        chk("t2_hits", 32'(done_hits), 32'd2);
        chk("t2_abort", 32'(done_abort), 32'd0);

        // Hit on the final bit.
        run_window(0, 8'b0000_1011, -1, '0, wcnt, cyc);
        chk("t3_hits", 32'(done_hits), 32'd1);
        chk("t3_abort", 32'(done_abort), 32'd0);

        // Abort in the 5th RUN cycle of source 2; then source 3 is next.
        req = 4'b0100;
        run_window(2, 8'b1011_0000, 4, 4'b1001, wcnt, cyc);
        chk("t5_id", 32'(done_id), 32'd2);
        chk("t5_hits", 32'(done_hits), 32'd1);
        chk("t5_abort", 32'(done_abort), 32'd1);
        wcnt = 0;
        while (!det_rst && wcnt < 20) begin
            step();
            wcnt++;
        end
        chk("t5_next_grant", 32'(grant), 32'b1000);

        // Reset during the 3rd RUN bit of source 3.
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_det_in", 32'(det_in), 32'd0);
        chk("t6_done_id", 32'(done_id), 32'd0);
        chk("t6_done_hits", 32'(done_hits), 32'd0);
        chk("t6_done_abort", 32'(done_abort), 32'd0);
        rst = 1'b0;
        req = 4'b0100;
        run_window(2, 8'b1011_1011, -1, '0, wcnt, cyc);
        req = '0;
        chk("t6_id", 32'(done_id), 32'd2);
        chk("t6_hits", 32'(done_hits), 32'd2);
        chk("t6_abort", 32'(done_abort), 32'd0);
        step();
        step();
        chk("done_pulse_count", 32'(done_pulses), 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Round-robin scheduler that time-shares one serial sequence detector (ports clk, rst, in, out) among N serial sources.
- Per grant: clears the detector, streams WINDOW bits from the granted source into it, counts detector hits, then reports the count with the source ID.
- Sits between the serial sources and the shared detector instance.

Parameters:
N, 4, number of requesters/serial sources (>=2)
WINDOW, 8, bits streamed per grant (>=2)
IDW, $clog2(N), requester ID width
CW, $clog2(WINDOW+1), hit counter width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  N  per-source request level; held high while the source wants service
ser_in  input  N  per-source serial bit; sampled only for the granted source
grant  output  N  one-hot grant, registered; high during CLEAR and RUN
busy  output  1  high in any state other than IDLE
det_rst  output  1  drives the detector's rst; high one cycle in CLEAR
det_in  output  1  drives the detector's in; ser_in[gid] in RUN, else 0
det_hit  input  1  detector's out; Mealy, valid in the same cycle as det_in
done  output  1  one-cycle pulse in REPORT
done_id  output  IDW  ID reported with done; held until next done
done_hits  output  CW  hits counted in the window; held until next done
done_abort  output  1  window ended early; held until next done

Behaviour:
- Reset, sampled at a clock edge:
  - state=IDLE, rr_ptr=0, gid=0, bit_cnt=0, hit_cnt=0.
  - grant=0, busy=0, det_rst=0, det_in=0, done=0, done_id=0, done_hits=0, done_abort=0.
  - Reset mid-window discards the window; no done is produced.
- States: IDLE -> CLEAR -> RUN -> REPORT -> IDLE.
- IDLE:
  - If req!=0, pick the first set bit searching upward from rr_ptr, wrapping at N-1 -> 0.
  - Register gid and grant; go to CLEAR.
  - If req==0, stay in IDLE.
- CLEAR (1 cycle):
  - det_rst=1, det_in=0.
  - bit_cnt=0, hit_cnt=0; go to RUN.
- RUN:
  - det_in = ser_in[gid]; each cycle bit_cnt+=1, and hit_cnt+=1 if det_hit=1.
  - After the WINDOW-th RUN cycle (bit_cnt==WINDOW-1), go to REPORT with abort=0. A hit on the last bit is counted.
  - If req[gid]==0 in a RUN cycle: that cycle's bit is not streamed (det_in=0, det_hit ignored). Go to REPORT with abort=1 and hit_cnt as it stands.
  - Abort has priority over window end in the same cycle.
- REPORT (1 cycle):
  - done=1; done_id, done_hits, done_abort registered on entry and held afterwards.
  - grant=0; rr_ptr = gid+1, wrapping N-1 -> 0.
  - Go to IDLE.
  - New requests are evaluated only in IDLE, so at least one idle cycle separates grants.
- Timing: req seen at edge E0 -> CLEAR in the cycle after E0 -> RUN for cycles after E1..E(WINDOW) -> done high in the cycle after E(WINDOW+1). That is WINDOW+2 cycles from request sample to done for a full window.
- Requests from non-granted sources are ignored until IDLE; they may change freely.
- hit_cnt cannot overflow: the maximum is WINDOW, which fits in CW.

Test Plan:
(Bench instantiates an overlapping Mealy "1011" detector on det_rst/det_in/det_hit; WINDOW=8, N=4.)
1. Reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0, busy=0, done=0, det_rst=0. First grant after rst falls goes to ID 0.
2. req=4'b0001, ser_in[0]=1,0,1,1,0,1,1,0 -> det_rst pulse, grant=4'b0001 for 9 cycles, done 10 cycles after the req sample, done_id=0, done_hits=2, done_abort=0.
3. Final-bit hit: ser_in[0]=0,0,0,0,1,0,1,1 -> done_hits=1 (hit on the 8th bit counted).
4. Round-robin: req=4'b1111 held -> done_id sequence 0,1,2,3,0, with exactly one IDLE cycle between each REPORT and the next CLEAR.
5. Abort: source 2 granted with ser_in[2]=1,0,1,1,..., req[2] dropped in the 5th RUN cycle -> done_abort=1, done_hits=1, done_id=2. The next grant goes to ID 3 when req[3]=1 and req[0]=1.
6. Reset mid-RUN (3rd bit) -> all outputs reset the next cycle, no done pulse. A fresh req=4'b0100 then runs a full window with done_id=2.
